// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite encodings, FSM states and burst address helpers
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA_LAST,
        ST_ERR
    } state_t;

    function automatic logic [15:0] burst_beats(input logic [2:0] burst, input logic [15:0] len);
        case (burst)
            HBURST_INCR:                 burst_beats = (len == 16'd0) ? 16'd1 : len;
            HBURST_WRAP4, HBURST_INCR4:  burst_beats = 16'd4;
            HBURST_WRAP8, HBURST_INCR8:  burst_beats = 16'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 16'd16;
            default:                     burst_beats = 16'd1;
        endcase
    endfunction

    // Wrapping bursts keep the upper address bits and roll the offset inside a beats*inc window.
    function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [2:0] burst,
                                              input logic [2:0] size);
        logic [63:0] inc;
        logic [63:0] span;
        logic [63:0] nxt;
        inc  = 64'd1 << size;
        nxt  = addr + inc;
        span = 64'(burst_beats(burst, 16'd1)) << size;
        if (burst != HBURST_SINGLE && !burst[0])
            next_addr = (addr & ~(span - 64'd1)) | (nxt & (span - 64'd1));
        else
            next_addr = nxt;
    endfunction

endpackage

// File: rtl/ahb_burst_master_if.sv
// rtl/ahb_burst_master_if.sv - AHB-Lite master/slave signal bundle
interface ahb_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] HADDR;
    logic [2:0]        HBURST;
    logic [2:0]        HSIZE;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        output HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_burst_regfile.sv
// rtl/ahb_burst_regfile.sv - register file with bus/host write ports and bypassed host read
module ahb_burst_regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_DEPTH = 8,
    localparam int IDX_W    = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bw_en,
    input  logic [IDX_W-1:0]  bw_addr,
    input  logic [DATA_W-1:0] bw_data,
    input  logic              hw_en,
    input  logic [IDX_W-1:0]  hw_addr,
    input  logic [DATA_W-1:0] hw_data,
    input  logic [IDX_W-1:0]  br_addr,
    output logic [DATA_W-1:0] br_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [REG_DEPTH];

    // Bus write is applied last so it wins if both ports ever hit the same entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (hw_en) mem[hw_addr] <= hw_data;
            if (bw_en) mem[bw_addr] <= bw_data;
        end
    end

    assign br_data = mem[br_addr];

    always_comb begin
        rd_data = mem[rd_addr];
        if (bw_en && bw_addr == rd_addr)
            rd_data = bw_data;
        else if (hw_en && hw_addr == rd_addr)
            rd_data = hw_data;
    end
endmodule

// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - pipelined AHB-Lite burst master; AHB_BURST_MASTER_STATS_EN enables beat/wait counters
module ahb_burst_master
    import ahb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int REG_DEPTH = 8,
    parameter int LEN_W     = 8,
    localparam int IDX_W    = $clog2(REG_DEPTH)
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    input  logic [2:0]        cmd_burst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [IDX_W-1:0]  cmd_reg,
    output logic              done,
    output logic              err,
    input  logic              rf_wr_en,
    input  logic [IDX_W-1:0]  rf_wr_addr,
    input  logic [DATA_W-1:0] rf_wr_data,
    input  logic [IDX_W-1:0]  rf_rd_addr,
    output logic [DATA_W-1:0] rf_rd_data,
    ahb_burst_master_if.master ahb,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_waits
);
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] haddr_q, haddr_n, nxt_addr;
    logic [1:0]        htrans_q, htrans_n;
    logic [2:0]        hburst_q, hburst_n, hsize_q, hsize_n;
    logic              hwrite_q, hwrite_n;
    logic [DATA_W-1:0] hwdata_q, hwdata_n, br_data;
    logic [15:0]       remain_q, remain_n;
    logic [IDX_W-1:0]  a_idx_q, a_idx_n, dp_idx_q, dp_idx_n;
    logic              dp_q, dp_n, done_q, done_n, err_q, err_n;
    logic              bw_en, hw_en;

    assign nxt_addr  = ADDR_W'(next_addr(64'(haddr_q), hburst_q, hsize_q));
    assign cmd_ready = (state_q == ST_IDLE);
    assign hw_en     = rf_wr_en && cmd_ready && !bw_en;

    always_comb begin
        state_n  = state_q;
        haddr_n  = haddr_q;
        htrans_n = htrans_q;
        hburst_n = hburst_q;
        hsize_n  = hsize_q;
        hwrite_n = hwrite_q;
        hwdata_n = hwdata_q;
        remain_n = remain_q;
        a_idx_n  = a_idx_q;
        dp_idx_n = dp_idx_q;
        dp_n     = dp_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        bw_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_size > MAX_SIZE) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = ST_ADDR;
                        haddr_n  = cmd_addr;
                        htrans_n = HTRANS_NONSEQ;
                        hburst_n = cmd_burst;
                        hsize_n  = cmd_size;
                        hwrite_n = cmd_write;
                        remain_n = burst_beats(cmd_burst, 16'(cmd_len)) - 16'd1;
                        a_idx_n  = cmd_reg;
                    end
                end
            end
            ST_ADDR: begin
                if (dp_q && ahb.HRESP) begin
                    // First ERROR cycle cancels the pending address phase even though HREADY is low.
                    htrans_n = HTRANS_IDLE;
                    dp_n     = 1'b0;
                    state_n  = ahb.HREADY ? ST_IDLE : ST_ERR;
                    err_n    = ahb.HREADY;
                end else if (ahb.HREADY) begin
                    bw_en    = dp_q && !hwrite_q;
                    dp_n     = 1'b1;
                    dp_idx_n = a_idx_q;
                    if (hwrite_q) hwdata_n = br_data;
                    if (remain_q == 16'd0) begin
                        htrans_n = HTRANS_IDLE;
                        state_n  = ST_DATA_LAST;
                    end else begin
                        haddr_n  = nxt_addr;
                        htrans_n = (hburst_q == HBURST_INCR && nxt_addr[9:0] == 10'd0) ?
                                   HTRANS_NONSEQ : HTRANS_SEQ;
                        remain_n = remain_q - 16'd1;
                        a_idx_n  = a_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DATA_LAST: begin
                if (ahb.HREADY) begin
                    dp_n    = 1'b0;
                    state_n = ST_IDLE;
                    if (ahb.HRESP) begin
                        err_n = 1'b1;
                    end else begin
                        done_n = 1'b1;
                        bw_en  = !hwrite_q;
                    end
                end else if (ahb.HRESP) begin
                    dp_n    = 1'b0;
                    state_n = ST_ERR;
                end
            end
            ST_ERR: begin
                if (ahb.HREADY) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hburst_q <= '0;
            hsize_q  <= '0;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            remain_q <= '0;
            a_idx_q  <= '0;
            dp_idx_q <= '0;
            dp_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            haddr_q  <= haddr_n;
            htrans_q <= htrans_n;
            hburst_q <= hburst_n;
            hsize_q  <= hsize_n;
            hwrite_q <= hwrite_n;
            hwdata_q <= hwdata_n;
            remain_q <= remain_n;
            a_idx_q  <= a_idx_n;
            dp_idx_q <= dp_idx_n;
            dp_q     <= dp_n;
            done_q   <= done_n;
            err_q    <= err_n;
        end
    end

    ahb_burst_regfile #(.DATA_W(DATA_W), .REG_DEPTH(REG_DEPTH)) u_regfile (
        .clk     (HCLK),
        .rst     (HRESET),
        .bw_en   (bw_en),
        .bw_addr (dp_idx_q),
        .bw_data (ahb.HRDATA),
        .hw_en   (hw_en),
        .hw_addr (rf_wr_addr),
        .hw_data (rf_wr_data),
        .br_addr (a_idx_q),
        .br_data (br_data),
        .rd_addr (rf_rd_addr),
        .rd_data (rf_rd_data)
    );

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HBURST = hburst_q;
    assign ahb.HSIZE  = hsize_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HWDATA = hwdata_q;
    assign done       = done_q;
    assign err        = err_q;

`ifdef AHB_BURST_MASTER_STATS_EN
    logic [31:0] beats_q, waits_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            beats_q <= '0;
            waits_q <= '0;
        end else begin
            if (dp_q && ahb.HREADY && !ahb.HRESP && beats_q != '1)
                beats_q <= beats_q + 32'd1;
            if (!ahb.HREADY && (dp_q || htrans_q != HTRANS_IDLE) && waits_q != '1)
                waits_q <= waits_q + 32'd1;
        end
    end

    assign stat_beats = beats_q;
    assign stat_waits = waits_q;
`else
    assign stat_beats = '0;
    assign stat_waits = '0;
`endif
endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - directed self-checking bench for ahb_burst_master
module tb_ahb_burst_master;
    import ahb_pkg::*;

    localparam int DATA_W = 32, ADDR_W = 32, REG_DEPTH = 8, LEN_W = 8, IDX_W = 3;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              cmd_valid, cmd_write, cmd_ready, done, err;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size, cmd_burst;
    logic [LEN_W-1:0]  cmd_len;
    logic [IDX_W-1:0]  cmd_reg, rf_wr_addr, rf_rd_addr;
    logic              rf_wr_en;
    logic [DATA_W-1:0] rf_wr_data, rf_rd_data;
    logic [31:0]       stat_beats, stat_waits;
    int                checks = 0;
    int                failures = 0;

    logic [31:0] t1_addr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [31:0] t2_addr [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    logic [31:0] t2_data [4] = '{32'hA, 32'hB, 32'hC, 32'hD};
    logic [31:0] t4_addr [4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    logic [1:0]  t4_trans [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] t4_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    ahb_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_DEPTH(REG_DEPTH), .LEN_W(LEN_W)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .cmd_len    (cmd_len),
        .cmd_reg    (cmd_reg),
        .done       (done),
        .err        (err),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .ahb        (bus),
        .stat_beats (stat_beats),
        .stat_waits (stat_waits)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [2:0] b, input logic [7:0] len, input logic [2:0] r);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_size  = sz;
        cmd_burst = b;
        cmd_len   = len;
        cmd_reg   = r;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] r, input logic [31:0] exp, input string tag);
        rf_rd_addr = r;
        #1;
        check(tag, rf_rd_data, exp);
    endtask

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0;
        cmd_burst = '0; cmd_len = '0; cmd_reg = '0; rf_wr_en = 1'b0; rf_wr_addr = '0;
        rf_wr_data = '0; rf_rd_addr = '0;
        bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        tick();
        tick();
        HRESET = 1'b0;
        check("rst htrans", bus.HTRANS, 2'b00);
        check("rst haddr", bus.HADDR, 32'h0);
        check("rst hwdata", bus.HWDATA, 32'h0);
        check("rst ready/done/err", {cmd_ready, done, err}, 3'b100);
        check("rst stats", {stat_beats, stat_waits}, 64'h0);
        read_reg(3'd0, 32'h0, "rst reg0");

        // Host preload reg0..3 = 1..4, checking bypass on the write cycle
        for (int i = 0; i < 4; i++) begin
            rf_wr_en = 1'b1; rf_wr_addr = 3'(i); rf_wr_data = 32'(i + 1);
            read_reg(3'(i), 32'(i + 1), $sformatf("host bypass r%0d", i));
            tick();
        end
        rf_wr_en = 1'b0;

        // T1: INCR4 write at 0x100
        issue(32'h100, 1'b1, 3'd2, HBURST_INCR4, 8'd0, 3'd0);
        for (int n = 1; n <= 7; n++) begin
            if (n <= 4) begin
                check($sformatf("t1 haddr n%0d", n), bus.HADDR, t1_addr[n-1]);
                check($sformatf("t1 htrans n%0d", n), bus.HTRANS, (n == 1) ? 2'b10 : 2'b11);
            end
            if (n >= 2 && n <= 5) check($sformatf("t1 hwdata n%0d", n), bus.HWDATA, 32'(n - 1));
            if (n == 5) check("t1 htrans idle", bus.HTRANS, 2'b00);
            if (n == 6) check("t1 cmd_ready", cmd_ready, 1'b1);
            check($sformatf("t1 done n%0d", n), done, n == 6);
            tick();
        end

        // T2: WRAP4 read at 0x38 into reg4..7
        issue(32'h38, 1'b0, 3'd2, HBURST_WRAP4, 8'd0, 3'd4);
        for (int n = 1; n <= 6; n++) begin
            if (n <= 4) check($sformatf("t2 haddr n%0d", n), bus.HADDR, t2_addr[n-1]);
            if (n >= 2 && n <= 5) begin
                bus.HRDATA = t2_data[n-2];
                read_reg(3'(4 + n - 2), t2_data[n-2], $sformatf("t2 wb bypass n%0d", n));
            end
            check($sformatf("t2 done n%0d", n), done, n == 6);
            tick();
        end
        for (int i = 0; i < 4; i++) read_reg(3'(4 + i), t2_data[i], $sformatf("t2 reg%0d", 4 + i));

        // T3: INCR8 write at 0x200 with two stall cycles during beat 3 data phase
        issue(32'h200, 1'b1, 3'd2, HBURST_INCR8, 8'd0, 3'd0);
        for (int n = 1; n <= 12; n++) begin
            bus.HREADY = !(n == 5 || n == 6);
            rf_wr_en = (n == 3); rf_wr_addr = 3'd7; rf_wr_data = 32'hEE;
            if (n >= 5 && n <= 7)
                check($sformatf("t3 stable n%0d", n),
                      {bus.HADDR, bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE, bus.HWDATA},
                      {32'h210, 2'b11, 3'd5, 3'd2, 1'b1, 32'd4});
            if (n == 11) check("t3 last hwdata", {bus.HTRANS, bus.HWDATA}, {2'b00, 32'hD});
            check($sformatf("t3 done n%0d", n), done, n == 12);
            tick();
        end
        bus.HREADY = 1'b1; rf_wr_en = 1'b0;
        read_reg(3'd7, 32'hD, "t3 busy host write ignored");
`ifdef AHB_BURST_MASTER_STATS_EN
        check("t3 stat_waits", stat_waits, 32'd2);
        check("t3 stat_beats", stat_beats, 32'd16);
`else
        check("t3 stats tied", {stat_beats, stat_waits}, 64'h0);
`endif

        // T4: INCR len 4 read across the 1KB boundary
        issue(32'h3F8, 1'b0, 3'd2, HBURST_INCR, 8'd4, 3'd0);
        for (int n = 1; n <= 6; n++) begin
            if (n <= 4) begin
                check($sformatf("t4 haddr n%0d", n), bus.HADDR, t4_addr[n-1]);
                check($sformatf("t4 htrans n%0d", n), bus.HTRANS, t4_trans[n-1]);
                check($sformatf("t4 hburst n%0d", n), bus.HBURST, 3'd1);
            end
            if (n >= 2 && n <= 5) bus.HRDATA = t4_data[n-2];
            check($sformatf("t4 done n%0d", n), done, n == 6);
            tick();
        end
        read_reg(3'd0, 32'h11, "t4 reg0");
        read_reg(3'd3, 32'h44, "t4 reg3");

        // T5: INCR4 read into reg4..7 with ERROR on beat 2
        issue(32'h500, 1'b0, 3'd2, HBURST_INCR4, 8'd0, 3'd4);
        for (int n = 1; n <= 7; n++) begin
            bus.HREADY = (n != 4);
            bus.HRESP  = (n == 4 || n == 5);
            bus.HRDATA = (n == 2) ? 32'h55 : (n == 3) ? 32'h66 : 32'h77;
            if (n == 5) check("t5 htrans idle after error", bus.HTRANS, 2'b00);
            check($sformatf("t5 err n%0d", n), err, n == 6);
            check($sformatf("t5 done n%0d", n), done, 1'b0);
            tick();
        end
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        read_reg(3'd4, 32'h55, "t5 reg4");
        read_reg(3'd5, 32'h66, "t5 reg5");
        read_reg(3'd6, 32'hC, "t5 errored beat reg6");
        read_reg(3'd7, 32'hD, "t5 cancelled reg7");

        // T6: illegal size on a 32-bit bus
        issue(32'h40, 1'b1, 3'd3, HBURST_INCR4, 8'd0, 3'd0);
        check("t6 err", {err, bus.HTRANS, cmd_ready}, {1'b1, 2'b00, 1'b1});
        tick();
        check("t6 err clears", {err, bus.HTRANS, done}, {1'b0, 2'b00, 1'b0});

        // T7: host write in the accept cycle feeds a SINGLE write
        rf_wr_en = 1'b1; rf_wr_addr = 3'd0; rf_wr_data = 32'h99;
        issue(32'h600, 1'b1, 3'd2, HBURST_SINGLE, 8'd0, 3'd0);
        rf_wr_en = 1'b0;
        check("t7 nonseq", {bus.HTRANS, bus.HADDR, bus.HBURST}, {2'b10, 32'h600, 3'd0});
        tick();
        check("t7 hwdata", {bus.HTRANS, bus.HWDATA}, {2'b00, 32'h99});
        tick();
        check("t7 done", done, 1'b1);
        tick();

        // T8: reset in the middle of an INCR16
        issue(32'h700, 1'b1, 3'd2, HBURST_INCR16, 8'd0, 3'd0);
        for (int n = 1; n < 5; n++) tick();
        check("t8 mid burst", {bus.HTRANS, bus.HADDR}, {2'b11, 32'h710});
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        check("t8 reset outputs", {bus.HTRANS, bus.HADDR, bus.HWDATA, cmd_ready},
              {2'b00, 32'h0, 32'h0, 1'b1});
        tick();
        check("t8 quiet", {bus.HTRANS, done, err}, {2'b00, 1'b0, 1'b0});
        read_reg(3'd4, 32'h0, "t8 regs cleared");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
